rtc_write_sequencer: RTL and testbench
======================================

Name: rtc_write_sequencer

Overview:
- Controller that sequences the RTC write datapath and shares it between three requesters: init, format update and user programming.
- Drives the datapath select lines `dir_sel`, `data_sel`, `sel_prog`, `Addr_I`, `Addr_W` and `Addr_L`.
- Generates multiplexed address/data bus strobes so that each register write is one address phase plus one data phase.
- Sits between the top-level control FSM (requests) and the write datapath and bus pads.

Parameters:
- T_PULSE, 4, cycles `wr_n` is held low per phase (≥1)
- T_GAP, 2, cycles `cs_n` is held high after each phase (≥1)
- INIT_N, 4, number of init-table writes (`Addr_I` 0..INIT_N-1, ≤16)
- PROG_N, 9, number of parameter writes (`sel_prog`/`Addr_W` 0..PROG_N-1, ≤16)
- FMT_ADDR_H, 4'h2, `Addr_L` value for the hour-format write
- FMT_ADDR_T, 4'h3, `Addr_L` value for the timer-format write

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_init  in  1  request init sequence (sampled per cycle)
- req_fmt  in  1  request format write pair
- req_prog  in  1  request parameter programming
- dir_sel  out  2  address source: 00 Addr_L, 01 Addr_W, 10 Addr_I
- data_sel  out  2  data source: 00 Data_WI, 01 Data_WF, 10 Data_I, 11 Data_WR
- sel_prog  out  4  parameter index
- Addr_I  out  4  init-table index
- Addr_W  out  4  parameter register index (equals `sel_prog`)
- Addr_L  out  4  format register address
- cs_n  out  1  chip select
- wr_n  out  1  write strobe
- rd_n  out  1  read strobe, held at 1
- a_d  out  1  bus phase: 0 address, 1 data
- bus_oe  out  1  pad output enable
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse at end of an operation
- done_op  out  2  operation just finished: 01 init, 10 fmt, 11 prog; valid with `done`

Behaviour:
- Reset (reset=0, asynchronous):
  - `cs_n`=1, `wr_n`=1, `rd_n`=1, `a_d`=0, `bus_oe`=0, `busy`=0, `done`=0, `done_op`=00.
  - All selects and indices are 0; pending flags and counters are cleared; FSM goes to IDLE.
- Reset mid-operation: the bus is released immediately. There is no resume; the requester must re-request.
- Pending flags: a request high in any cycle sets its flag. The flag clears when the FSM enters that operation's first SETUP_A. Requests arriving while busy are not lost; duplicates while pending merge.
- Arbitration (IDLE only): priority init > fmt > prog. Simultaneous requests are serviced back-to-back in priority order, each with its own `done` pulse.
- FSM states: IDLE → SETUP_A → WR_A → HOLD_A → GAP_A → SETUP_D → WR_D → HOLD_D → GAP_D → NEXT.
  - SETUP_A/D: 1 cycle. `cs_n`=0, `bus_oe`=1, `wr_n`=1, `a_d`=0 in the address phase and 1 in the data phase.
  - WR_A/D: T_PULSE cycles, `wr_n`=0.
  - HOLD_A/D: 1 cycle, `wr_n`=1, `cs_n`=0.
  - GAP_A/D: T_GAP cycles. `cs_n`=1, `bus_oe`=0; `a_d` holds the phase value.
  - NEXT: 0 cycles (combinational decision). Advance the index and go to SETUP_A, or on the last write go to IDLE with `done`=1 and `done_op` set for one cycle.
- One write takes 2·(T_PULSE+T_GAP+2) cycles; with defaults that is 16.
- Selects are set on entry to SETUP_A and stay stable until the write leaves GAP_D. They never change while `cs_n`=0.
- Operation tables:
  - init: `dir_sel`=10, `data_sel`=10, `Addr_I`=k for k=0..INIT_N-1.
  - fmt: write 0 uses `dir_sel`=00, `Addr_L`=FMT_ADDR_H, `data_sel`=00. Write 1 uses `Addr_L`=FMT_ADDR_T, `data_sel`=01.
  - prog: `dir_sel`=01, `data_sel`=11, `sel_prog`=`Addr_W`=k for k=0..PROG_N-1.
- `busy`=1 from SETUP_A of the first write through GAP_D of the last write. In the `done` cycle `busy`=0 unless the next pending operation starts in the following cycle.
- Phase counter width is $clog2(max(T_PULSE,T_GAP)+1). The counter reloads on every state entry and never wraps.
- Index counter is 4 bits and compares against N-1. N=1 gives a single write.

Decomposition:
- Shared package `rtc_bus_pkg`:
  - FSM state enum.
  - `dir_sel` encodings (DIR_L, DIR_W, DIR_I).
  - `data_sel` encodings (DAT_WI, DAT_WF, DAT_I, DAT_WR).
  - `done_op` codes.
- One natural sub-module, `bus_phase_timer`: generates the SETUP/WR/HOLD/GAP strobes for a single phase, started by a pulse and returning phase_done. The top level instantiates it once; the FSM reuses it for the address and data phases.

Test Plan:
- Reset with all requests high, reset low for 3 cycles → `cs_n`=`wr_n`=`rd_n`=1, `bus_oe`=0, `busy`=0 during reset; no bus activity until reset is released.
- `req_init` pulse at cycle 0 (defaults) → `cs_n` falls at cycle 1; `wr_n` low cycles 2–5 with `a_d`=0 and cycles 10–13 with `a_d`=1; `Addr_I` steps 0,1,2,3 at cycles 1,17,33,49; `done`=1 with `done_op`=01 at cycle 65.
- `req_prog` → 9 writes, `sel_prog`=`Addr_W` 0..8, `data_sel`=11, `dir_sel`=01; `done_op`=11 after 144 cycles.
- `req_fmt` and `req_prog` asserted in the same cycle → fmt runs first (`Addr_L` 2 then 3, `data_sel` 00 then 01) → `done_op`=10, then prog starts on the next cycle.
- `req_init` pulsed mid-prog at write 4 → prog completes all 9 writes, then init runs; selects never change while `cs_n`=0.
- Reset asserted during WR_D of prog write 2 → same cycle: `wr_n`=1, `cs_n`=1, `bus_oe`=0, `busy`=0; after release, IDLE with no pending requests.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared types and encodings for the RTC write sequencer and its bus phase timer.
package rtc_bus_pkg;

    // Operation-level sequencer state. Together with the timer phase below it
    // realises IDLE, SETUP_A..GAP_A (SQ_ADDR) and SETUP_D..GAP_D (SQ_DATA).
    typedef enum logic [1:0] {
        SQ_IDLE = 2'd0,
        SQ_ADDR = 2'd1,
        SQ_DATA = 2'd2
    } seq_e;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_SETUP = 3'd1,
        PH_WR    = 3'd2,
        PH_HOLD  = 3'd3,
        PH_GAP   = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_INIT = 2'b01,
        OP_FMT  = 2'b10,
        OP_PROG = 2'b11
    } op_e;

    localparam logic [1:0] DIR_L = 2'b00;
    localparam logic [1:0] DIR_W = 2'b01;
    localparam logic [1:0] DIR_I = 2'b10;

    localparam logic [1:0] DAT_WI = 2'b00;
    localparam logic [1:0] DAT_WF = 2'b01;
    localparam logic [1:0] DAT_I  = 2'b10;
    localparam logic [1:0] DAT_WR = 2'b11;

    typedef struct packed {
        logic [1:0] dir;
        logic [1:0] dat;
        logic [3:0] prog;
        logic [3:0] addr_i;
        logic [3:0] addr_l;
    } sel_t;

endpackage

// File: rtl/bus_phase_timer.sv
// One bus phase: SETUP (1) -> WR (T_PULSE) -> HOLD (1) -> GAP (T_GAP), with strobes.
// A start in the last GAP cycle chains straight into the next phase's SETUP.
module bus_phase_timer
    import rtc_bus_pkg::*;
#(
    parameter int T_PULSE = 4,
    parameter int T_GAP   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic phase_a_d,
    output logic cs_n,
    output logic wr_n,
    output logic bus_oe,
    output logic a_d,
    output logic phase_done
);

    localparam int T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
    localparam int CW    = $clog2(T_MAX + 1);

    phase_e        ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          a_d_q, a_d_d;

    assign phase_done = (ph_q == PH_GAP) && (cnt_q == '0);

    always_comb begin
        ph_d  = ph_q;
        cnt_d = cnt_q;
        a_d_d = a_d_q;
        case (ph_q)
            PH_IDLE: begin
                if (start) begin
                    ph_d  = PH_SETUP;
                    cnt_d = '0;
                    a_d_d = phase_a_d;
                end
            end
            PH_SETUP: begin
                ph_d  = PH_WR;
                cnt_d = CW'(T_PULSE - 1);
            end
            PH_WR: begin
                if (cnt_q == '0) begin
                    ph_d  = PH_HOLD;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PH_HOLD: begin
                ph_d  = PH_GAP;
                cnt_d = CW'(T_GAP - 1);
            end
            PH_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (start) begin
                    ph_d  = PH_SETUP;
                    cnt_d = '0;
                    a_d_d = phase_a_d;
                end else begin
                    ph_d  = PH_IDLE;
                    cnt_d = '0;
                end
            end
            default: begin
                ph_d  = PH_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_q  <= PH_IDLE;
            cnt_q <= '0;
            a_d_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            cnt_q <= cnt_d;
            a_d_q <= a_d_d;
        end
    end

    // Strobes decode straight from the registered phase so reset releases the bus at once.
    assign cs_n   = !((ph_q == PH_SETUP) || (ph_q == PH_WR) || (ph_q == PH_HOLD));
    assign bus_oe = (ph_q == PH_SETUP) || (ph_q == PH_WR) || (ph_q == PH_HOLD);
    assign wr_n   = (ph_q != PH_WR);
    assign a_d    = a_d_q;

endmodule

// File: rtl/rtc_write_sequencer.sv
// Arbitrates init / format / programming requests and sequences each register write
// as an address phase followed by a data phase on the multiplexed RTC bus.
module rtc_write_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int         T_PULSE    = 4,
    parameter int         T_GAP      = 2,
    parameter int         INIT_N     = 4,
    parameter int         PROG_N     = 9,
    parameter logic [3:0] FMT_ADDR_H = 4'h2,
    parameter logic [3:0] FMT_ADDR_T = 4'h3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_init,
    input  logic       req_fmt,
    input  logic       req_prog,
    output logic [1:0] dir_sel,
    output logic [1:0] data_sel,
    output logic [3:0] sel_prog,
    output logic [3:0] Addr_I,
    output logic [3:0] Addr_W,
    output logic [3:0] Addr_L,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a_d,
    output logic       bus_oe,
    output logic       busy,
    output logic       done,
    output logic [1:0] done_op
);

    seq_e       seq_q, seq_d;
    op_e        op_q, op_d;
    op_e        done_op_q, done_op_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] pend_q, pend_d;
    logic       done_q, done_d;
    sel_t       sel_q, sel_d;

    logic [2:0] want;
    logic       last;
    logic       tm_start;
    logic       tm_a_d;
    logic       phase_done;

    // Only the fields owned by the operation are touched; the rest keep their value.
    function automatic sel_t sel_for(input op_e op, input logic [3:0] k, input sel_t cur);
        sel_t s;
        s = cur;
        case (op)
            OP_INIT: begin
                s.dir    = DIR_I;
                s.dat    = DAT_I;
                s.addr_i = k;
            end
            OP_FMT: begin
                s.dir    = DIR_L;
                s.dat    = (k == 4'd0) ? DAT_WI : DAT_WF;
                s.addr_l = (k == 4'd0) ? FMT_ADDR_H : FMT_ADDR_T;
            end
            OP_PROG: begin
                s.dir  = DIR_W;
                s.dat  = DAT_WR;
                s.prog = k;
            end
            default: s = cur;
        endcase
        return s;
    endfunction

    // Bit 0 init, bit 1 fmt, bit 2 prog; a live request is granted in the same cycle.
    assign want = pend_q | {req_prog, req_fmt, req_init};

    always_comb begin
        case (op_q)
            OP_INIT: last = (idx_q == 4'(INIT_N - 1));
            OP_FMT:  last = (idx_q == 4'd1);
            OP_PROG: last = (idx_q == 4'(PROG_N - 1));
            default: last = 1'b1;
        endcase
    end

    always_comb begin
        seq_d     = seq_q;
        op_d      = op_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        pend_d    = want;
        done_d    = 1'b0;
        done_op_d = OP_NONE;
        tm_start  = 1'b0;
        tm_a_d    = 1'b0;
        case (seq_q)
            SQ_IDLE: begin
                if (|want) begin
                    if (want[0]) begin
                        op_d      = OP_INIT;
                        pend_d[0] = 1'b0;
                    end else if (want[1]) begin
                        op_d      = OP_FMT;
                        pend_d[1] = 1'b0;
                    end else begin
                        op_d      = OP_PROG;
                        pend_d[2] = 1'b0;
                    end
                    idx_d    = 4'd0;
                    sel_d    = sel_for(op_d, 4'd0, sel_q);
                    seq_d    = SQ_ADDR;
                    tm_start = 1'b1;
                end
            end
            SQ_ADDR: begin
                if (phase_done) begin
                    seq_d    = SQ_DATA;
                    tm_start = 1'b1;
                    tm_a_d   = 1'b1;
                end
            end
            SQ_DATA: begin
                if (phase_done) begin
                    if (last) begin
                        seq_d     = SQ_IDLE;
                        done_d    = 1'b1;
                        done_op_d = op_q;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        sel_d    = sel_for(op_q, idx_d, sel_q);
                        seq_d    = SQ_ADDR;
                        tm_start = 1'b1;
                    end
                end
            end
            default: seq_d = SQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_q     <= SQ_IDLE;
            op_q      <= OP_NONE;
            idx_q     <= 4'd0;
            pend_q    <= 3'b000;
            done_q    <= 1'b0;
            done_op_q <= OP_NONE;
            sel_q     <= '0;
        end else begin
            seq_q     <= seq_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
            done_op_q <= done_op_d;
            sel_q     <= sel_d;
        end
    end

    bus_phase_timer #(
        .T_PULSE(T_PULSE),
        .T_GAP  (T_GAP)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .start     (tm_start),
        .phase_a_d (tm_a_d),
        .cs_n      (cs_n),
        .wr_n      (wr_n),
        .bus_oe    (bus_oe),
        .a_d       (a_d),
        .phase_done(phase_done)
    );

    // In the done cycle busy stays up only when another operation starts next cycle.
    assign busy     = (seq_q != SQ_IDLE) || (done_q && (|want));
    assign done     = done_q;
    assign done_op  = done_op_q;
    assign dir_sel  = sel_q.dir;
    assign data_sel = sel_q.dat;
    assign sel_prog = sel_q.prog;
    assign Addr_W   = sel_q.prog;
    assign Addr_I   = sel_q.addr_i;
    assign Addr_L   = sel_q.addr_l;
    assign rd_n     = 1'b1;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Directed bench for rtc_write_sequencer with default parameters (16 cycles per write).
module tb_rtc_write_sequencer;

    logic       clk;
    logic       reset;
    logic       req_init, req_fmt, req_prog;
    logic [1:0] dir_sel, data_sel, done_op;
    logic [3:0] sel_prog, Addr_I, Addr_W, Addr_L;
    logic       cs_n, wr_n, rd_n, a_d, bus_oe, busy, done;

    int vectors    = 0;
    int miscompares = 0;

    rtc_write_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .req_init(req_init),
        .req_fmt (req_fmt),
        .req_prog(req_prog),
        .dir_sel (dir_sel),
        .data_sel(data_sel),
        .sel_prog(sel_prog),
        .Addr_I  (Addr_I),
        .Addr_W  (Addr_W),
        .Addr_L  (Addr_L),
        .cs_n    (cs_n),
        .wr_n    (wr_n),
        .rd_n    (rd_n),
        .a_d     (a_d),
        .bus_oe  (bus_oe),
        .busy    (busy),
        .done    (done),
        .done_op (done_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, " cs_n"}, 8'(cs_n), 8'h1);
        chk({tag, " wr_n"}, 8'(wr_n), 8'h1);
        chk({tag, " rd_n"}, 8'(rd_n), 8'h1);
        chk({tag, " bus_oe"}, 8'(bus_oe), 8'h0);
        chk({tag, " busy"}, 8'(busy), 8'h0);
    endtask

    // Called in the cycle the operation is granted; walks every cycle of all n writes
    // and then checks the done cycle. inj > 0 pulses req_init in that cycle.
    task automatic run_op(input logic [1:0] op, input int n, input int inj, input logic busy_at_done);
        int         off, w;
        logic       e_cs, e_wr, e_ad;
        logic [1:0] e_dir, e_dat;
        string      t;
        for (int c = 1; c <= 16 * n; c++) begin
            tick();
            req_init = (c == inj);
            req_fmt  = 1'b0;
            req_prog = 1'b0;
            off  = (c - 1) % 16;
            w    = (c - 1) / 16;
            e_cs = !((off <= 5) || (off >= 8 && off <= 13));
            e_wr = !((off >= 1 && off <= 4) || (off >= 9 && off <= 12));
            e_ad = (off >= 8);
            e_dir = (op == 2'b01) ? 2'b10 : (op == 2'b10) ? 2'b00 : 2'b01;
            e_dat = (op == 2'b01) ? 2'b10 : (op == 2'b10) ? 2'(w) : 2'b11;
            t = $sformatf("op%0d c%0d", op, c);
            chk({t, " cs_n"}, 8'(cs_n), 8'(e_cs));
            chk({t, " wr_n"}, 8'(wr_n), 8'(e_wr));
            chk({t, " a_d"}, 8'(a_d), 8'(e_ad));
            chk({t, " bus_oe"}, 8'(bus_oe), 8'(!e_cs));
            chk({t, " rd_n"}, 8'(rd_n), 8'h1);
            chk({t, " busy"}, 8'(busy), 8'h1);
            chk({t, " done"}, 8'(done), 8'h0);
            chk({t, " dir_sel"}, 8'(dir_sel), 8'(e_dir));
            chk({t, " data_sel"}, 8'(data_sel), 8'(e_dat));
            if (op == 2'b01) begin
                chk({t, " Addr_I"}, 8'(Addr_I), 8'(w));
            end else if (op == 2'b10) begin
                chk({t, " Addr_L"}, 8'(Addr_L), (w == 0) ? 8'h2 : 8'h3);
            end else begin
                chk({t, " sel_prog"}, 8'(sel_prog), 8'(w));
                chk({t, " Addr_W"}, 8'(Addr_W), 8'(w));
            end
        end
        tick();
        req_init = 1'b0;
        t = $sformatf("op%0d done", op);
        chk({t, " done"}, 8'(done), 8'h1);
        chk({t, " done_op"}, 8'(done_op), 8'(op));
        chk({t, " busy"}, 8'(busy), 8'(busy_at_done));
        chk({t, " cs_n"}, 8'(cs_n), 8'h1);
    endtask

    initial begin
        // Reset with every request high: bus must stay released.
        reset    = 1'b0;
        req_init = 1'b1;
        req_fmt  = 1'b1;
        req_prog = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_bus($sformatf("rst%0d", i));
            chk($sformatf("rst%0d done", i), 8'(done), 8'h0);
            chk($sformatf("rst%0d done_op", i), 8'(done_op), 8'h0);
            chk($sformatf("rst%0d a_d", i), 8'(a_d), 8'h0);
            chk($sformatf("rst%0d dir_sel", i), 8'(dir_sel), 8'h0);
            chk($sformatf("rst%0d sel_prog", i), 8'(sel_prog), 8'h0);
        end
        req_init = 1'b0;
        req_fmt  = 1'b0;
        req_prog = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_bus($sformatf("post_rst%0d", i));
        end

        // Init sequence from a single-cycle request.
        req_init = 1'b1;
        run_op(2'b01, 4, -1, 1'b0);
        tick();
        chk_idle_bus("after_init");
        chk("after_init done", 8'(done), 8'h0);
        chk("after_init done_op", 8'(done_op), 8'h0);

        // Parameter programming alone.
        req_prog = 1'b1;
        run_op(2'b11, 9, -1, 1'b0);
        tick();
        chk_idle_bus("after_prog");

        // fmt and prog together, init pulsed during prog write 4: fmt, prog, init back-to-back.
        req_fmt  = 1'b1;
        req_prog = 1'b1;
        run_op(2'b10, 2, -1, 1'b1);
        run_op(2'b11, 9, 4 * 16 + 3, 1'b1);
        run_op(2'b01, 4, -1, 1'b0);
        tick();
        chk_idle_bus("after_chain");

        // Reset in WR_D of prog write 2 releases the bus in the same cycle.
        req_prog = 1'b1;
        for (int c = 1; c <= 43; c++) begin
            tick();
            req_prog = 1'b0;
        end
        chk("mid wr_n", 8'(wr_n), 8'h0);
        chk("mid a_d", 8'(a_d), 8'h1);
        chk("mid sel_prog", 8'(sel_prog), 8'h2);
        #2;
        reset = 1'b0;
        #1;
        chk_idle_bus("async_rst");
        chk("async_rst sel_prog", 8'(sel_prog), 8'h0);
        chk("async_rst a_d", 8'(a_d), 8'h0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle_bus($sformatf("rst_release%0d", i));
            chk($sformatf("rst_release%0d done", i), 8'(done), 8'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
